// File: rtl/fatores_recompositor_engine_pkg.sv
// Shared definitions for the factor recomposition engine: slot count, the
// "no factor" fill value used by the factorizer, default widths and FSM states.
package fatores_recompositor_engine_pkg;

  localparam int NUM_SLOTS  = 4;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_EXP_W  = 4;
  localparam int EMPTY_CODE = 88;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NEXT = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fatores_recompositor_engine_shift_add_mul.sv
// Sequential LSB-first shift-add multiplier. A start pulse loads the operands;
// the next WIDTH cycles each add one partial product. done is high during the
// final step and product then shows the completed result combinationally, so
// the caller can capture it on the same edge that retires the last step.
module fatores_recompositor_engine_shift_add_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] mc_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   mp_q;
  logic [CNT_W-1:0]   step_q;
  logic               busy_q;

  assign busy    = busy_q;
  assign done    = busy_q && (step_q == CNT_W'(WIDTH - 1));
  assign product = prod_q + (mp_q[0] ? mc_q : '0);

  // Operand load on start, then one shift-add step per cycle while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mc_q   <= '0;
      prod_q <= '0;
      mp_q   <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      mc_q   <= {{WIDTH{1'b0}}, mcand};
      prod_q <= '0;
      mp_q   <= mplier;
      step_q <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      prod_q <= product;
      mc_q   <= mc_q << 1;
      mp_q   <= mp_q >> 1;
      step_q <= step_q + CNT_W'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fatores_recompositor_engine.sv
// Factor recomposition engine: rebuilds p0^e0 * p1^e1 * p2^e2 * p3^e3 by
// repeated shift-add multiplication, skipping slots holding 0, 1 or the
// factorizer's empty code. Stops early on the first product that overflows.
// Build option PRODUCT_SAT_EN: saturate out to all ones on overflow; without
// it out carries the low bits of the overflowing partial product.
module fatores_recompositor_engine
  import fatores_recompositor_engine_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EXP_W = DEF_EXP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] p0,
  input  logic [WIDTH-1:0] p1,
  input  logic [WIDTH-1:0] p2,
  input  logic [WIDTH-1:0] p3,
  input  logic [EXP_W-1:0] e0,
  input  logic [EXP_W-1:0] e1,
  input  logic [EXP_W-1:0] e2,
  input  logic [EXP_W-1:0] e3,
  output logic             ready,
  output logic [WIDTH-1:0] out,
  output logic             overflow
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   p_q [NUM_SLOTS];
  logic [EXP_W-1:0]   e_q [NUM_SLOTS];
  logic [WIDTH-1:0]   acc_q;
  logic [2:0]         slot_q;
  logic [EXP_W-1:0]   cnt_q;
  logic               ovf_q;
  logic [WIDTH-1:0]   out_q;
  logic               overflow_q;

  logic [1:0]         slot_idx;
  logic               slot_end;
  logic               cur_unused;
  logic               advance;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic               prod_hi_nz;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   done_val;

  assign slot_idx   = slot_q[1:0];
  assign slot_end   = (slot_q == 3'(NUM_SLOTS));
  assign cur_unused = (p_q[slot_idx] == WIDTH'(EMPTY_CODE)) || (p_q[slot_idx] <= WIDTH'(1));
  assign prod_hi_nz = |mul_prod[2*WIDTH-1:WIDTH];

  assign ready    = (state_q == ST_IDLE);
  assign out      = out_q;
  assign overflow = overflow_q;

`ifdef PRODUCT_SAT_EN
  assign done_val = ovf_q ? {WIDTH{1'b1}} : acc_q;
`else
  assign done_val = acc_q;
`endif

  fatores_recompositor_engine_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .mcand   (acc_q),
    .mplier  (p_q[slot_idx]),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode plus slot-advance and multiplier-launch strobes.
  always_comb begin
    state_d   = state_q;
    advance   = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_NEXT;
      ST_NEXT: begin
        if (slot_end) begin
          state_d = ST_DONE;
        end else if ((cnt_q == '0) || cur_unused) begin
          advance = 1'b1;
        end else begin
          mul_start = 1'b1;
          state_d   = ST_MUL;
        end
      end
      ST_MUL:  if (mul_busy && mul_done) state_d = prod_hi_nz ? ST_DONE : ST_NEXT;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture, slot/exponent sequencing, accumulator and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        p_q[i] <= '0;
        e_q[i] <= '0;
      end
      acc_q      <= '0;
      slot_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      out_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          p_q[0] <= p0;
          p_q[1] <= p1;
          p_q[2] <= p2;
          p_q[3] <= p3;
          e_q[0] <= e0;
          e_q[1] <= e1;
          e_q[2] <= e2;
          e_q[3] <= e3;
          acc_q  <= WIDTH'(1);
          slot_q <= '0;
          cnt_q  <= e0;
          ovf_q  <= 1'b0;
        end
        ST_NEXT: if (advance) begin
          slot_q <= slot_q + 3'd1;
          cnt_q  <= (slot_q < 3'(NUM_SLOTS - 1)) ? e_q[slot_idx + 2'd1] : '0;
        end
        ST_MUL: if (mul_busy && mul_done) begin
          acc_q <= mul_prod[WIDTH-1:0];
          if (prod_hi_nz) ovf_q <= 1'b1;
          else            cnt_q <= cnt_q - EXP_W'(1);
        end
        ST_DONE: begin
          out_q      <= done_val;
          overflow_q <= ovf_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fatores_recompositor_engine.sv
// Self-checking bench for fatores_recompositor_engine: directed cases plus
// randomized requests compared against a plain-arithmetic reference model.
// Honours PRODUCT_SAT_EN when the same define is given to the build.
module tb_fatores_recompositor_engine;

  localparam int W = 16;
`ifdef PRODUCT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0;
  logic [3:0]  e0 = '0, e1 = '0, e2 = '0, e3 = '0;
  logic        ready;
  logic [15:0] out;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  logic [15:0] tp [4];
  logic [3:0]  te [4];
  logic [15:0] last_out;

  fatores_recompositor_engine dut (
    .clk(clk), .reset(reset), .start(start),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3),
    .e0(e0), .e1(e1), .e2(e2), .e3(e3),
    .ready(ready), .out(out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic bit unused_f(input logic [15:0] v);
    return (v == 16'd88) || (v == 16'd0) || (v == 16'd1);
  endfunction

  // Reference: multiply factor by factor in slot order, stop at first overflow.
  function automatic void model(output logic [15:0] o, output logic ov, output int m);
    logic [31:0] acc;
    logic [31:0] full;
    acc = 32'd1;
    ov  = 1'b0;
    m   = 0;
    for (int i = 0; i < 4; i++) begin
      if (!unused_f(tp[i])) begin
        m += int'(te[i]);
        for (int k = 0; k < int'(te[i]); k++) begin
          if (!ov) begin
            full = acc * {16'd0, tp[i]};
            acc  = {16'd0, full[15:0]};
            if (full > 32'h0000_FFFF) ov = 1'b1;
          end
        end
      end
    end
    o = (ov && SAT) ? 16'hFFFF : acc[15:0];
  endfunction

  task automatic launch();
    p0 = tp[0]; p1 = tp[1]; p2 = tp[2]; p3 = tp[3];
    e0 = te[0]; e1 = te[1]; e2 = te[2]; e3 = te[3];
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Launch one request, count cycles with ready low; optionally re-pulse start mid-run.
  task automatic do_op(input int glitch_at, output int lat, output logic [15:0] mid_out);
    lat = 0;
    mid_out = '0;
    launch();
    while (lat < 2000) begin
      @(negedge clk);
      if (ready) break;
      lat++;
      if (lat == glitch_at) mid_out = out;
      start = (lat == glitch_at);
    end
    start = 1'b0;
  endtask

  task automatic run_case(input string tag, input int glitch_at);
    logic [15:0] eo, mo;
    logic        eov;
    int          m, lat;
    model(eo, eov, m);
    do_op(glitch_at, lat, mo);
    chk({tag, "_timeout"}, 32'(lat < 2000), 32'd1);
    chk({tag, "_out"}, 32'(out), 32'(eo));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eov));
    if (!eov) chk({tag, "_lat"}, 32'(lat), 32'((W + 1) * m + 6));
    if (glitch_at > 0) chk({tag, "_held"}, 32'(mo), 32'(last_out));
    last_out = eo;
  endtask

  task automatic set_case(input logic [15:0] a, b, c, d, input logic [3:0] w, x, y, z);
    tp[0] = a; tp[1] = b; tp[2] = c; tp[3] = d;
    te[0] = w; te[1] = x; te[2] = y; te[3] = z;
  endtask

  function automatic logic [15:0] pick_factor();
    logic [15:0] lst [9];
    int r;
    lst = '{16'd0, 16'd1, 16'd88, 16'd2, 16'd3, 16'd5, 16'd7, 16'd11, 16'd13};
    r = int'($urandom_range(0, 9));
    if (r == 9) return 16'($urandom_range(2, 60));
    return lst[r];
  endfunction

  initial begin
    last_out = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    set_case(16'd2, 16'd3, 16'd5, 16'd88, 4'd3, 4'd1, 4'd1, 4'd0);
    run_case("T1", 0);
    chk("T1_val", 32'(out), 32'd120);
    set_case(16'd88, 16'd88, 16'd88, 16'd88, 4'd7, 4'd2, 4'd9, 4'd15);
    run_case("T2", 0);
    set_case(16'd2, 16'd88, 16'd88, 16'd88, 4'd15, 4'd0, 4'd0, 4'd0);
    run_case("T3a", 0);
    chk("T3a_val", 32'(out), 32'd32768);
    set_case(16'd2, 16'd2, 16'd88, 16'd88, 4'd15, 4'd1, 4'd0, 4'd0);
    run_case("T3b", 0);
    chk("T3b_val", 32'(out), SAT ? 32'hFFFF : 32'h0);
    set_case(16'd7, 16'd0, 16'd1, 16'd13, 4'd2, 4'd5, 4'd9, 4'd1);
    run_case("T4", 0);
    set_case(16'd2, 16'd3, 16'd5, 16'd88, 4'd3, 4'd1, 4'd1, 4'd0);
    run_case("T5", 10);
    set_case(16'd2, 16'd3, 16'd5, 16'd7, 4'd1, 4'd1, 4'd1, 4'd1);
    run_case("RT210", 0);
    set_case(16'd3, 16'd11, 16'd13, 16'd88, 4'd1, 4'd1, 4'd1, 4'd0);
    run_case("RT429", 0);

    // Reset in the middle of a multiply, between clock edges.
    set_case(16'd7, 16'd0, 16'd1, 16'd13, 4'd2, 4'd5, 4'd9, 4'd1);
    launch();
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("T6_ready", 32'(ready), 32'd1);
    chk("T6_out", 32'(out), 32'd0);
    chk("T6_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    last_out = '0;
    set_case(16'd2, 16'd3, 16'd5, 16'd88, 4'd3, 4'd1, 4'd1, 4'd0);
    run_case("T6_after", 0);

    for (int n = 0; n < 40; n++) begin
      for (int s = 0; s < 4; s++) begin
        tp[s] = pick_factor();
        te[s] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      end
      run_case($sformatf("rnd%0d", n), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
